// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler
//   Sequences the game time base: runs the game-phase FSM, gates the time
//   base enable, divides the time-base pulse into ball and brick step
//   strobes, and shortens the brick-fall period as the level rises.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   start      in   single-cycle command: IDLE->RUN, OVER->IDLE
//   pause_req  in   single-cycle toggle: RUN<->PAUSE
//   game_over  in   single-cycle loss indication from game logic
//   pulse      in   single-cycle tick from the time base
//   tb_enable  out  time base enable, high exactly while state==RUN
//   ball_step  out  single-cycle ball move strobe
//   brick_step out  single-cycle brick fall strobe
//   level      out  current difficulty level (saturates at 15)
//   state      out  0=IDLE 1=RUN 2=PAUSE 3=OVER (also the FSM debug view)
//
// Strobe semantics: every input command and pulse is a one-cycle strobe
// sampled on the rising edge; there is no back-pressure. ball_step and
// brick_step rise on the edge that consumes the completing pulse and are
// cleared on the following edge, so they are high for exactly one cycle.
module game_tick_scheduler #(
    parameter int BALL_DIV       = 2,
    parameter int BRICK_DIV_INIT = 8,
    parameter int BRICK_DIV_MIN  = 4,
    parameter int BRICK_DIV_STEP = 2,
    parameter int LEVEL_UP_DROPS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause_req,
    input  logic       game_over,
    input  logic       pulse,
    output logic       tb_enable,
    output logic       ball_step,
    output logic       brick_step,
    output logic [3:0] level,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [15:0] BALL_LAST  = 16'(BALL_DIV - 1);
    localparam logic [15:0] DROP_LAST  = 16'(LEVEL_UP_DROPS - 1);
    localparam logic [7:0]  DIV_INIT   = 8'(BRICK_DIV_INIT);
    localparam logic [7:0]  DIV_MIN    = 8'(BRICK_DIV_MIN);
    localparam logic [7:0]  DIV_STEP   = 8'(BRICK_DIV_STEP);
    // Below this threshold the decrement would undershoot the floor (or wrap).
    localparam logic [8:0]  DIV_THRESH = 9'(BRICK_DIV_MIN + BRICK_DIV_STEP);

    state_t      st;
    logic [15:0] ball_cnt;
    logic [7:0]  brick_cnt;
    logic [15:0] drop_cnt;
    logic [7:0]  brick_div;

    assign state = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= IDLE;
            tb_enable  <= 1'b0;
            ball_step  <= 1'b0;
            brick_step <= 1'b0;
            level      <= 4'd0;
            ball_cnt   <= '0;
            brick_cnt  <= '0;
            drop_cnt   <= '0;
            brick_div  <= DIV_INIT;
        end else begin
            ball_step  <= 1'b0;
            brick_step <= 1'b0;
            case (st)
                IDLE: begin
                    if (start) begin
                        st        <= RUN;
                        tb_enable <= 1'b1;
                    end
                end
                RUN: begin
                    // game_over discards a coincident pulse entirely; a
                    // coincident pause_req still lets the pulse count.
                    if (game_over) begin
                        st        <= OVER;
                        tb_enable <= 1'b0;
                    end else begin
                        if (pause_req) begin
                            st        <= PAUSE;
                            tb_enable <= 1'b0;
                        end
                        if (pulse) begin
                            if (ball_cnt == BALL_LAST) begin
                                ball_cnt  <= '0;
                                ball_step <= 1'b1;
                            end else begin
                                ball_cnt <= ball_cnt + 16'd1;
                            end
                            if (brick_cnt == brick_div - 8'd1) begin
                                brick_cnt  <= '0;
                                brick_step <= 1'b1;
                                // Level-up rides on the brick wrap; the new
                                // period takes effect from the next period.
                                if (drop_cnt == DROP_LAST) begin
                                    drop_cnt <= '0;
                                    if (level != 4'hF)
                                        level <= level + 4'd1;
                                    if ({1'b0, brick_div} < DIV_THRESH)
                                        brick_div <= DIV_MIN;
                                    else
                                        brick_div <= brick_div - DIV_STEP;
                                end else begin
                                    drop_cnt <= drop_cnt + 16'd1;
                                end
                            end else begin
                                brick_cnt <= brick_cnt + 8'd1;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (game_over) begin
                        st <= OVER;
                    end else if (pause_req) begin
                        st        <= RUN;
                        tb_enable <= 1'b1;
                    end
                end
                OVER: begin
                    // Counters and level stay frozen for display until start.
                    if (start) begin
                        st        <= IDLE;
                        level     <= 4'd0;
                        ball_cnt  <= '0;
                        brick_cnt <= '0;
                        drop_cnt  <= '0;
                        brick_div <= DIV_INIT;
                    end
                end
                default: begin
                    st        <= IDLE;
                    tb_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_tick_scheduler.sv
module tb_game_tick_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause_req = 1'b0;
    logic       game_over = 1'b0;
    logic       pulse = 1'b0;
    logic       tb_enable;
    logic       ball_step;
    logic       brick_step;
    logic [3:0] level;
    logic [1:0] state;

    int vectors = 0;
    int errors  = 0;

    // Brick wrap points counted from start with default parameters:
    // period 8 for four drops, 6 for four drops, then floored at 4.
    int brick_at [14] = '{8, 16, 24, 32, 38, 44, 50, 56, 60, 64, 68, 72, 76, 80};

    game_tick_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause_req  (pause_req),
        .game_over  (game_over),
        .pulse      (pulse),
        .tb_enable  (tb_enable),
        .ball_step  (ball_step),
        .brick_step (brick_step),
        .level      (level),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ball0"}, 32'(ball_step), 32'd0);
        chk({tag, "_brick0"}, 32'(brick_step), 32'd0);
    endtask

    // One pulse, check the strobes on the next cycle, then gap idle cycles
    // in which both strobes must be low.
    task automatic pulse_chk(input string tag, input logic eb, input logic ebr, input int gap);
        pulse = 1'b1;
        step();
        pulse = 1'b0;
        chk({tag, "_ball"}, 32'(ball_step), 32'(eb));
        chk({tag, "_brick"}, 32'(brick_step), 32'(ebr));
        for (int g = 0; g < gap; g++) begin
            step();
            chk_quiet(tag);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause_req = 1'b1;
        step();
        pause_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic logic brick_exp(input int n);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 14; k++)
            if (brick_at[k] == n) hit = 1'b1;
        return hit;
    endfunction

    initial begin
        // Reset held with start asserted: reset must win every cycle.
        reset = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_state", 32'(state), 32'd0);
            chk("rst_tben", 32'(tb_enable), 32'd0);
            chk("rst_level", 32'(level), 32'd0);
            chk_quiet("rst");
        end
        reset = 1'b0;
        start = 1'b0;
        step();
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_tben", 32'(tb_enable), 32'd0);

        // Step division: ball every 2nd pulse, brick on the 8th.
        do_start();
        chk("div_state", 32'(state), 32'd1);
        chk("div_tben", 32'(tb_enable), 32'd1);
        for (int i = 1; i <= 8; i++)
            pulse_chk("div", logic'(i % 2 == 0), logic'(i == 8), 4);
        chk("div_level", 32'(level), 32'd0);

        // Level-up and period floor from a fresh start.
        do_reset();
        do_start();
        for (int i = 1; i <= 80; i++) begin
            pulse_chk("lvl", logic'(i % 2 == 0), brick_exp(i), 1);
            chk("lvl_level", 32'(level),
                (i >= 72) ? 32'd3 : (i >= 56) ? 32'd2 : (i >= 32) ? 32'd1 : 32'd0);
        end

        // Pause: pulses ignored, counts resume where they stopped.
        do_reset();
        do_start();
        for (int i = 1; i <= 3; i++)
            pulse_chk("pre", logic'(i == 2), 1'b0, 1);
        do_pause();
        chk("pause_state", 32'(state), 32'd2);
        chk("pause_tben", 32'(tb_enable), 32'd0);
        for (int i = 0; i < 10; i++)
            pulse_chk("paused", 1'b0, 1'b0, 1);
        chk("paused_state", 32'(state), 32'd2);
        pause_req = 1'b1;
        start = 1'b1;
        step();
        pause_req = 1'b0;
        start = 1'b0;
        chk("resume_state", 32'(state), 32'd1);
        chk("resume_tben", 32'(tb_enable), 32'd1);
        for (int i = 1; i <= 5; i++)
            pulse_chk("post", logic'(i % 2 == 1), logic'(i == 5), 1);

        // Simultaneous pulse + pause_req + game_over with ball_cnt==1.
        pulse_chk("sim_pre", 1'b0, 1'b0, 1);
        pulse = 1'b1;
        pause_req = 1'b1;
        game_over = 1'b1;
        step();
        pulse = 1'b0;
        pause_req = 1'b0;
        game_over = 1'b0;
        chk("sim_state", 32'(state), 32'd3);
        chk("sim_tben", 32'(tb_enable), 32'd0);
        chk_quiet("sim");
        pulse_chk("over_pulse", 1'b0, 1'b0, 1);
        chk("over_hold", 32'(state), 32'd3);
        do_start();
        chk("over_idle", 32'(state), 32'd0);
        do_start();
        chk("rerun_state", 32'(state), 32'd1);
        chk("rerun_level", 32'(level), 32'd0);
        pulse_chk("rerun", 1'b0, 1'b0, 1);
        pulse_chk("rerun", 1'b1, 1'b0, 1);

        // Reset mid-run at level 2, with a pulse coincident with reset.
        do_reset();
        do_start();
        for (int i = 1; i <= 56; i++)
            pulse_chk("fast", logic'(i % 2 == 0), brick_exp(i), 0);
        chk("fast_level", 32'(level), 32'd2);
        reset = 1'b1;
        pulse = 1'b1;
        step();
        reset = 1'b0;
        pulse = 1'b0;
        chk("mrst_state", 32'(state), 32'd0);
        chk("mrst_tben", 32'(tb_enable), 32'd0);
        chk("mrst_level", 32'(level), 32'd0);
        chk_quiet("mrst");
        do_start();
        for (int i = 1; i <= 8; i++)
            pulse_chk("after", logic'(i % 2 == 0), logic'(i == 8), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
